// File: rtl/cache_req_driver_if.sv
// Processor-side bus between cache_req_driver and cache_system.
// master = request initiator, slave = cache/memory side.
interface cache_req_driver_if;
    logic        Mem_Write;
    logic        Mem_read;
    logic        stall;
    logic [31:0] a_data_mem;
    logic [31:0] w_data_mem;
    logic [31:0] r_data_mem;

    modport master (
        output Mem_Write,
        output Mem_read,
        output a_data_mem,
        output w_data_mem,
        input  stall,
        input  r_data_mem
    );

    modport slave (
        input  Mem_Write,
        input  Mem_read,
        input  a_data_mem,
        input  w_data_mem,
        output stall,
        output r_data_mem
    );
endinterface

// File: rtl/cache_req_driver.sv
// Self-checking request initiator for cache_system: read-check, write pattern, read-back.
// Define CACHE_REQ_TIMEOUT_EN to abort a run after TIMEOUT consecutive stall cycles.
module cache_req_driver #(
    parameter int unsigned NUM_REQ   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned STRIDE    = 1,
    parameter logic [31:0] WR_MASK   = 32'hA5A5_0000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    cache_req_driver_if.master        bus,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               pass_count,
    output logic [15:0]               fail_count,
    output logic [31:0]               first_fail_addr
);

    localparam int unsigned        IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [31:0]        ADDR_STEP = 32'(STRIDE * 4);
    localparam logic [31:0]        BASE_WDAT = (BASE_ADDR >> 2) ^ WR_MASK;

    if (NUM_REQ < 1 || TIMEOUT < 1) begin : g_param_check
        $error("cache_req_driver: NUM_REQ and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_INIT,
        WR,
        RD_BACK,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       word_idx;
    logic [31:0]       next_addr;
    logic [31:0]       expected;
    logic              rd_state;
    logic              rd_match;
    logic              last_acc;

    always_comb begin
        word_idx  = bus.a_data_mem >> 2;
        next_addr = bus.a_data_mem + ADDR_STEP;
        rd_state  = (state == RD_INIT) || (state == RD_BACK);
        expected  = (state == RD_BACK) ? (word_idx ^ WR_MASK) : word_idx;
        rd_match  = (bus.r_data_mem == expected);
        last_acc  = (idx == LAST_IDX);
    end

`ifdef CACHE_REQ_TIMEOUT_EN
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT - 1);
    logic [31:0] stall_cnt;
    logic        timeout_hit;

    always_comb timeout_hit = bus.stall && (stall_cnt == TO_LIM);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            bus.Mem_read    <= 1'b0;
            bus.Mem_Write   <= 1'b0;
            bus.a_data_mem  <= '0;
            bus.w_data_mem  <= '0;
            done            <= 1'b0;
            error           <= 1'b0;
            pass_count      <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
            stall_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RD_INIT;
                        idx             <= '0;
                        bus.Mem_read    <= 1'b1;
                        bus.Mem_Write   <= 1'b0;
                        bus.a_data_mem  <= BASE_ADDR;
                        bus.w_data_mem  <= '0;
                        done            <= 1'b0;
                        error           <= 1'b0;
                        pass_count      <= '0;
                        fail_count      <= '0;
                        first_fail_addr <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
                        stall_cnt       <= '0;
`endif
                    end
                end

                RD_INIT, WR, RD_BACK: begin
                    if (!bus.stall) begin
`ifdef CACHE_REQ_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                        // Check result is taken only on the completing edge.
                        if (rd_state) begin
                            if (rd_match) begin
                                if (pass_count != 16'hFFFF)
                                    pass_count <= pass_count + 16'd1;
                            end else begin
                                error <= 1'b1;
                                if (fail_count != 16'hFFFF)
                                    fail_count <= fail_count + 16'd1;
                                if (fail_count == 16'd0)
                                    first_fail_addr <= bus.a_data_mem;
                            end
                        end

                        if (last_acc) begin
                            idx            <= '0;
                            bus.a_data_mem <= BASE_ADDR;
                            case (state)
                                RD_INIT: begin
                                    state          <= WR;
                                    bus.Mem_read   <= 1'b0;
                                    bus.Mem_Write  <= 1'b1;
                                    bus.w_data_mem <= BASE_WDAT;
                                end
                                WR: begin
                                    state          <= RD_BACK;
                                    bus.Mem_read   <= 1'b1;
                                    bus.Mem_Write  <= 1'b0;
                                    bus.w_data_mem <= '0;
                                end
                                default: begin
                                    state          <= DONE;
                                    bus.Mem_read   <= 1'b0;
                                    bus.Mem_Write  <= 1'b0;
                                    bus.a_data_mem <= '0;
                                    done           <= 1'b1;
                                end
                            endcase
                        end else begin
                            idx            <= idx + 1'b1;
                            bus.a_data_mem <= next_addr;
                            if (state == WR)
                                bus.w_data_mem <= (next_addr >> 2) ^ WR_MASK;
                        end
                    end
`ifdef CACHE_REQ_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state          <= DONE;
                        bus.Mem_read   <= 1'b0;
                        bus.Mem_Write  <= 1'b0;
                        bus.w_data_mem <= '0;
                        done           <= 1'b1;
                        error          <= 1'b1;
                        stall_cnt      <= '0;
                        if (fail_count != 16'hFFFF)
                            fail_count <= fail_count + 16'd1;
                    end else begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
`endif
                end

                default: begin
                    state         <= IDLE;
                    bus.Mem_read  <= 1'b0;
                    bus.Mem_Write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_driver.sv
// Scoreboard bench for cache_req_driver: NUM_REQ=4, BASE=0, STRIDE=1, with an in-bench memory model.
module tb_cache_req_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic        error;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic [31:0] first_fail_addr;

    int checks = 0;
    int errors = 0;

    cache_req_driver_if bus();

    cache_req_driver #(
        .NUM_REQ  (4),
        .BASE_ADDR(32'h0),
        .STRIDE   (1),
        .WR_MASK  (32'hA5A5_0000),
        .TIMEOUT  (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bus            (bus),
        .done           (done),
        .error          (error),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // Memory model: power-up word A holds A/4; stall policy selected by stall_mode.
    int unsigned stall_mode  = 0;
    bit          corrupt_en  = 1'b0;
    bit          mem_init_req = 1'b1;
    int unsigned waited      = 0;
    logic [31:0] mem [0:63];
    logic        req;

    assign req = bus.Mem_read | bus.Mem_Write;
    assign bus.stall = (stall_mode == 1 && bus.Mem_read && waited < 3) ||
                       (stall_mode == 2 && req);
    assign bus.r_data_mem = (corrupt_en && bus.a_data_mem == 32'h8 && mem[2] != 32'd2)
                            ? 32'h0 : mem[bus.a_data_mem[7:2]];

    always @(posedge clk) begin
        if (mem_init_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (bus.Mem_Write && !bus.stall) begin
            mem[bus.a_data_mem[7:2]] <= bus.w_data_mem;
        end
        if (req && bus.stall) waited <= waited + 1;
        else                  waited <= 0;
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_run();
        txn_t t;
        for (int i = 0; i < 4; i++) begin
            t.wr = 1'b0; t.addr = 32'(4 * i); t.wdata = 32'h0; exp_q.push_back(t);
        end
        for (int i = 0; i < 4; i++) begin
            t.wr = 1'b1; t.addr = 32'(4 * i); t.wdata = 32'hA5A5_0000 | 32'(i); exp_q.push_back(t);
        end
        for (int i = 0; i < 4; i++) begin
            t.wr = 1'b0; t.addr = 32'(4 * i); t.wdata = 32'h0; exp_q.push_back(t);
        end
    endtask

    // Monitor: pops on every completing request; checks holds while stalled.
    initial begin
        txn_t snap;
        txn_t t;
        bit   prev_stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled && req) begin
                    chk("hold_kind", {30'b0, bus.Mem_Write, bus.Mem_read}, {30'b0, snap.wr, !snap.wr});
                    chk("hold_addr", bus.a_data_mem, snap.addr);
                    chk("hold_wdata", bus.w_data_mem, snap.wdata);
                end
                if (req && !bus.stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL txn_unexpected: got addr %h with no expected request", bus.a_data_mem);
                    end else begin
                        t = exp_q.pop_front();
                        chk("txn_kind", {30'b0, bus.Mem_Write, bus.Mem_read}, {30'b0, t.wr, !t.wr});
                        chk("txn_addr", bus.a_data_mem, t.addr);
                        chk("txn_wdata", bus.w_data_mem, t.wdata);
                    end
                end
                prev_stalled = req && bus.stall;
                snap.wr    = bus.Mem_Write;
                snap.addr  = bus.a_data_mem;
                snap.wdata = bus.w_data_mem;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic init_mem();
        @(negedge clk) mem_init_req = 1'b1;
        @(negedge clk) mem_init_req = 1'b0;
    endtask

    task automatic check_final(input string tag, input int p, input int f,
                               input logic e, input logic [31:0] a);
        chk({tag, "_pass"}, 32'(pass_count), 32'(p));
        chk({tag, "_fail"}, 32'(fail_count), 32'(f));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_first_fail"}, first_fail_addr, a);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_req_low"}, {30'b0, bus.Mem_read, bus.Mem_Write}, 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req"}, {30'b0, bus.Mem_read, bus.Mem_Write}, 32'd0);
        chk({tag, "_addr"}, bus.a_data_mem, 32'd0);
        chk({tag, "_wdata"}, bus.w_data_mem, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_pass"}, 32'(pass_count), 32'd0);
        chk({tag, "_fail"}, 32'(fail_count), 32'd0);
        chk({tag, "_first_fail"}, first_fail_addr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int guard;

        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        mem_init_req = 1'b0;

        // 1: no stall, 12-cycle run
        stall_mode = 0;
        push_run();
        pulse_start();
        wait_done(n);
        chk("t1_cycles", 32'(n), 32'd12);
        check_final("t1", 8, 0, 1'b0, 32'h0);

        // 2: every read stalled 3 cycles
        init_mem();
        stall_mode = 1;
        push_run();
        pulse_start();
        wait_done(n);
        chk("t2_cycles", 32'(n), 32'd36);
        check_final("t2", 8, 0, 1'b0, 32'h0);
        stall_mode = 0;

        // 3: read-back of address 8 corrupted
        init_mem();
        corrupt_en = 1'b1;
        push_run();
        pulse_start();
        wait_done(n);
        chk("t3_cycles", 32'(n), 32'd12);
        check_final("t3", 7, 1, 1'b1, 32'h8);
        corrupt_en = 1'b0;

        // 4: reset during WR index 2, then clean rerun
        init_mem();
        push_run();
        pulse_start();
        guard = 0;
        while (!(bus.Mem_Write && bus.a_data_mem == 32'h8) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("t4_reached_wr2", {30'b0, bus.Mem_Write, bus.Mem_read}, 32'd2);
        reset = 1'b1;
        #1 check_idle("t4_async");
        exp_q.delete();
        @(posedge clk);
        #1 check_idle("t4_edge");
        @(negedge clk);
        reset = 1'b0;
        init_mem();
        push_run();
        pulse_start();
        wait_done(n);
        chk("t4_cycles", 32'(n), 32'd12);
        check_final("t4", 8, 0, 1'b0, 32'h0);

        // 5: stall held forever
        stall_mode = 2;
        pulse_start();
`ifdef CACHE_REQ_TIMEOUT_EN
        wait_done(n);
        chk("t5_cycles", 32'(n), 32'd64);
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_fail", 32'(fail_count), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_rd_low", 32'(bus.Mem_read), 32'd0);
`else
        repeat (100) @(posedge clk);
        #1;
        chk("t5_done_low", 32'(done), 32'd0);
        chk("t5_rd_held", 32'(bus.Mem_read), 32'd1);
        chk("t5_addr_held", bus.a_data_mem, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;
        stall_mode = 0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
